// File: rtl/bitstream_eval_scheduler.sv
// Sequences one stochastic evaluation of the bitstream network: LFSR/comparator
// bit generation for STREAM_LEN cycles, pipeline drain, and a ones count returned via start/done.
module bitstream_eval_scheduler #(
    parameter int          N_INPUTS    = 2,
    parameter int          DATA_W      = 8,
    parameter int          STREAM_LEN  = 256,
    parameter int          NET_LATENCY = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         CNT_W       = $clog2(STREAM_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [N_INPUTS*DATA_W-1:0]   data_in,
    output logic                         busy,
    output logic                         net_clr,
    output logic                         net_en,
    output logic [N_INPUTS-1:0]          net_bits_out,
    input  logic                         net_bit_in,
    output logic [CNT_W-1:0]             result,
    output logic                         result_valid,
    output logic                         done
);

    localparam int DLY_W = (NET_LATENCY == 0) ? 1 : NET_LATENCY;
    localparam logic [15:0] RUN_LAST = 16'(STREAM_LEN - 1);
    localparam logic [3:0]  DRAIN_LAST = 4'(NET_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    state_t                       state;
    state_t                       next_state;
    logic [N_INPUTS*DATA_W-1:0]   values_q;
    logic [15:0]                  lfsr;
    logic [15:0]                  lfsr_next;
    logic [15:0]                  cmp_src;
    logic [31:0]                  rot_dbl;
    logic [N_INPUTS-1:0]          cmp_bits;
    logic [15:0]                  run_cnt;
    logic [3:0]                   drain_cnt;
    logic [DLY_W-1:0]             dly_q;
    logic                         sample_flag;
    logic [CNT_W-1:0]             ones_cnt;
    logic [CNT_W-1:0]             cnt_next;

    assign busy    = (state != IDLE);
    assign net_clr = (state == LOAD);
    assign net_en  = (state == RUN);
    assign done    = (state == DONE);

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = RUN;
            RUN:     if (run_cnt == RUN_LAST) next_state = (NET_LATENCY == 0) ? DONE : DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort && state != IDLE) next_state = IDLE;
    end

    // Bits registered for RUN cycle j come from the j-th LFSR state after the seed.
    always_comb begin
        cmp_src  = (state == RUN) ? lfsr_next : lfsr;
        cmp_bits = '0;
        rot_dbl  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            rot_dbl     = {cmp_src, cmp_src} << ((4 * i) % 16);
            cmp_bits[i] = values_q[i*DATA_W +: DATA_W] > rot_dbl[16 +: DATA_W];
        end
    end

    always_comb begin
        sample_flag = (NET_LATENCY == 0) ? net_en : dly_q[DLY_W-1];
        cnt_next    = ones_cnt + CNT_W'(sample_flag & net_bit_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            values_q     <= '0;
            lfsr         <= LFSR_SEED;
            run_cnt      <= '0;
            drain_cnt    <= '0;
            dly_q        <= '0;
            ones_cnt     <= '0;
            net_bits_out <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= next_state;
            // Flushing the window in IDLE keeps an aborted run from leaking samples.
            dly_q        <= (state == IDLE) ? '0 : ((dly_q << 1) | DLY_W'(net_en));
            ones_cnt     <= cnt_next;
            net_bits_out <= (next_state == RUN) ? cmp_bits : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        values_q     <= data_in;
                        lfsr         <= LFSR_SEED;
                        ones_cnt     <= '0;
                        result       <= '0;
                        result_valid <= 1'b0;
                    end
                end
                LOAD: begin
                    run_cnt   <= '0;
                    drain_cnt <= '0;
                end
                RUN: begin
                    lfsr    <= lfsr_next;
                    run_cnt <= run_cnt + 16'd1;
                end
                DRAIN:   drain_cnt <= drain_cnt + 4'd1;
                default: ;
            endcase
            if (next_state == DONE) begin
                result       <= cnt_next;
                result_valid <= 1'b1;
            end
            if (abort && state != IDLE) result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bitstream_eval_scheduler.sv
// Randomized bench for bitstream_eval_scheduler against a stream-level reference
// model; a second instance covers NET_LATENCY=0, STREAM_LEN=1.
module tb_bitstream_eval_scheduler;

    localparam int N_IN = 2;
    localparam int DW   = 8;
    localparam int L    = 256;
    localparam int NL   = 2;
    localparam int CW   = $clog2(L + 1);
    localparam int MODE_NORMAL = 0;
    localparam int MODE_PULSE  = 1;
    localparam int MODE_HOLD   = 2;

    logic              clk, rst;
    logic              start, abort;
    logic [N_IN*DW-1:0] data_in;
    logic              busy, net_clr, net_en, net_bit_in, result_valid, done;
    logic [N_IN-1:0]   net_bits_out;
    logic [CW-1:0]     result;
    logic [1:0]        pipe;

    logic              start2, abort2;
    logic [N_IN*DW-1:0] data2;
    logic              busy2, clr2, en2, valid2, done2;
    logic [N_IN-1:0]   bits2;
    logic [0:0]        result2;

    logic [N_IN-1:0]   exp_q[$];
    int                checks = 0;
    int                errors = 0;

    bitstream_eval_scheduler #(.STREAM_LEN(L), .NET_LATENCY(NL)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .data_in(data_in),
        .busy(busy), .net_clr(net_clr), .net_en(net_en), .net_bits_out(net_bits_out),
        .net_bit_in(net_bit_in), .result(result), .result_valid(result_valid), .done(done)
    );

    bitstream_eval_scheduler #(.STREAM_LEN(1), .NET_LATENCY(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .data_in(data2),
        .busy(busy2), .net_clr(clr2), .net_en(en2), .net_bits_out(bits2),
        .net_bit_in(bits2[0]), .result(result2), .result_valid(valid2), .done(done2)
    );

    // Clock / reset and the network stand-in: output = channel 0 delayed NL cycles.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[0], net_bits_out[0]};
    end
    assign net_bit_in = pipe[1];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: the stream of LFSR states from the seed, rotated per channel.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        logic fb;
        fb = s[16-16] ^ 1'b0;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    function automatic int chan_rand(input logic [15:0] s, input int ch);
        int sh;
        int w;
        int rot;
        sh  = (4 * ch) % 16;
        w   = int'(s);
        rot = ((w << sh) | (w >> (16 - sh))) & 32'hFFFF;
        return rot % 256;
    endfunction

    task automatic model_eval(input int v0, input int v1, input int len, input bit push, output int cnt);
        logic [15:0] s;
        logic        b0, b1;
        s   = 16'hACE1;
        cnt = 0;
        for (int j = 0; j < len; j++) begin
            b0 = (v0 > chan_rand(s, 0));
            b1 = (v1 > chan_rand(s, 1));
            if (push) exp_q.push_back({b1, b0});
            cnt += int'(b0);
            s = lfsr_adv(s);
        end
    endtask

    // Driver: call at a negedge with the DUT idle; returns at the first negedge after start is sampled.
    task automatic kick(input int v0, input int v1, input bit hold);
        data_in = {DW'(v1), DW'(v0)};
        start   = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic watch_eval(input int exp_cnt, input int mode);
        int cyc = 1;
        int en_cnt = 0;
        bit got = 0;
        logic [N_IN-1:0] e;
        check("load_clr", net_clr, 1);
        check("load_bits", net_bits_out, 0);
        for (int k = 0; k < 600; k++) begin
            if (done) begin
                got = 1;
                if (mode == MODE_PULSE) start = 1'b0;
                break;
            end
            if (net_en) begin
                en_cnt++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("run_bits", net_bits_out, e);
                end else begin
                    check("bits_queue_empty", 1, 0);
                end
            end
            if (mode == MODE_PULSE && busy) start = 1'($urandom_range(0, 1));
            if (mode != MODE_HOLD) data_in = N_IN*DW'($urandom);
            @(negedge clk);
            cyc++;
        end
        check("done_seen", got, 1);
        check("done_latency", cyc, L + NL + 2);
        check("en_cycles", en_cnt, L);
        check("result", result, exp_cnt);
        check("result_valid", result_valid, 1);
        check("busy_in_done", busy, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_net_en"}, net_en, 0);
        check({tag, "_net_clr"}, net_clr, 0);
        check({tag, "_bits"}, net_bits_out, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_valid"}, result_valid, 0);
    endtask

    initial begin
        int cnt, n, dn, cyc, v0, v1;
        bit seen;
        rst = 1'b1; start = 0; abort = 0; data_in = '0;
        start2 = 0; abort2 = 0; data2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // ch0 = 0: never fires
        model_eval(0, 37, L, 1, cnt);
        check("model_zero", cnt, 0);
        kick(0, 37, 0);
        watch_eval(cnt, MODE_NORMAL);
        @(negedge clk);
        check("hold_result", result, 0);
        check("hold_valid", result_valid, 1);
        check("done_pulse_width", done, 0);

        // ch0 = 255, twice: seed reload gives the same count
        for (int r = 0; r < 2; r++) begin
            model_eval(255, 200, L, 1, cnt);
            check("model_range", (cnt >= 250 && cnt <= 256), 1);
            kick(255, 200, 0);
            watch_eval(cnt, MODE_NORMAL);
            @(negedge clk);
        end

        model_eval(124, 82, L, 1, cnt);
        kick(124, 82, 0);
        watch_eval(cnt, MODE_NORMAL);
        @(negedge clk);

        repeat (3) begin
            v0 = $urandom_range(0, 255);
            v1 = $urandom_range(0, 255);
            model_eval(v0, v1, L, 1, cnt);
            kick(v0, v1, 0);
            watch_eval(cnt, MODE_NORMAL);
            @(negedge clk);
        end

        // abort after 100 RUN cycles
        kick(90, 10, 0);
        n = 0;
        for (int k = 0; k < 400; k++) begin
            if (net_en) n++;
            if (n == 100) break;
            @(negedge clk);
        end
        check("abort_reach", n, 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_net_en", net_en, 0);
        check("abort_valid", result_valid, 0);
        check("abort_done", done, 0);
        check("abort_bits", net_bits_out, 0);
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            dn += int'(done);
        end
        check("abort_no_done", dn, 0);
        model_eval(90, 10, L, 1, cnt);
        kick(90, 10, 0);
        watch_eval(cnt, MODE_NORMAL);
        @(negedge clk);

        // start held high: back-to-back runs with one IDLE cycle between
        v0 = $urandom_range(0, 255);
        v1 = $urandom_range(0, 255);
        model_eval(v0, v1, L, 1, cnt);
        model_eval(v0, v1, L, 1, cnt);
        kick(v0, v1, 1);
        watch_eval(cnt, MODE_HOLD);
        @(negedge clk);
        check("gap_idle", busy, 0);
        check("gap_no_done", done, 0);
        @(negedge clk);
        start = 1'b0;
        watch_eval(cnt, MODE_NORMAL);
        @(negedge clk);

        // stray start pulses while busy
        v0 = $urandom_range(0, 255);
        model_eval(v0, 5, L, 1, cnt);
        kick(v0, 5, 0);
        watch_eval(cnt, MODE_PULSE);
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            dn += int'(done);
        end
        check("pulse_no_extra_done", dn, 0);
        check("pulse_idle", busy, 0);

        // asynchronous reset during DRAIN
        kick(200, 100, 0);
        seen = 0;
        for (int k = 0; k < 600; k++) begin
            if (net_en) seen = 1;
            else if (seen) break;
            @(negedge clk);
        end
        check("drain_reach", busy && !net_en && !done, 1);
        #2 rst = 1'b1;
        #1 check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);

        // short instance: STREAM_LEN=1, NET_LATENCY=0
        for (int r = 0; r < 2; r++) begin
            v0 = (r == 0) ? 0 : 255;
            model_eval(v0, 0, 1, 0, cnt);
            data2  = {8'd0, 8'(v0)};
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            cyc = 1;
            check("short_load_clr", clr2, 1);
            for (int k = 0; k < 20; k++) begin
                if (done2) break;
                @(negedge clk);
                cyc++;
            end
            check("short_latency", cyc, 3);
            check("short_done", done2, 1);
            check("short_result", result2, cnt);
            check("short_valid", valid2, 1);
            @(negedge clk);
            check("short_idle", busy2, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitstream_eval_scheduler.md
Name: bitstream_eval_scheduler

Overview:
- Sequences one stochastic evaluation of the bitstream neural network (network_control datapath).
- Converts latched integer inputs into per-cycle stochastic bits using an LFSR and comparators.
- Gates the network for a fixed stream length, waits out the network pipeline latency, and counts ones on the network's output bit.
- Returns the count as the result with a start/done handshake; sits between the board-level top and the network datapath.

Parameters:
- N_INPUTS, 2, number of network input channels.
- DATA_W, 8, width of each input value.
- STREAM_LEN, 256, number of bitstream cycles per evaluation; range 1..65535.
- NET_LATENCY, 2, network pipeline depth in cycles from net_bits_out to net_bit_in; range 0..15.
- LFSR_SEED, 16'hACE1, LFSR reload value; must be nonzero.

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, request an evaluation; sampled only in IDLE.
- abort, in, 1, cancel an evaluation in progress.
- data_in, in, N_INPUTS*DATA_W, input values; channel i occupies bits [i*DATA_W +: DATA_W].
- busy, out, 1, high in every state except IDLE.
- net_clr, out, 1, one-cycle clear pulse to the network datapath.
- net_en, out, 1, network advance enable; high exactly during RUN.
- net_bits_out, out, N_INPUTS, stochastic input bits to the network.
- net_bit_in, in, 1, network output bitstream.
- result, out, CNT_W, count of ones; CNT_W = $clog2(STREAM_LEN+1).
- result_valid, out, 1, result holds a completed evaluation.
- done, out, 1, one-cycle completion pulse.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high. Ports are clk and rst.
- Reset values: state=IDLE, busy=0, net_clr=0, net_en=0, net_bits_out=0, result=0, result_valid=0, done=0, LFSR=LFSR_SEED, all counters 0.
- IDLE:
  - start=1 latches data_in, reloads LFSR=LFSR_SEED, clears result and ones counter, clears result_valid, then goes to LOAD.
  - start=0 stays in IDLE.
- LOAD (1 cycle): net_clr=1, then goes to RUN.
- RUN (exactly STREAM_LEN cycles):
  - net_en=1; LFSR advances every cycle.
  - LFSR is 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifting left with feedback into bit0.
  - Channel i uses r_i = low DATA_W bits of (LFSR rotated left by 4*i).
  - net_bits_out[i] = (latched value_i > r_i), registered.
  - net_bits_out is 0 in all other states.
  - After the last RUN cycle goes to DRAIN.
- Sample window: a valid flag equal to net_en, delayed by NET_LATENCY cycles.
  - The ones counter increments when the delayed flag=1 and net_bit_in=1.
  - Exactly STREAM_LEN samples are taken; the counter never exceeds STREAM_LEN.
  - NET_LATENCY=0 samples in the same cycle as net_en.
- DRAIN (NET_LATENCY cycles; skipped if NET_LATENCY=0): keeps counting delayed samples.
- DONE (1 cycle): result=counter, result_valid=1, done=1, then goes to IDLE.
- result and result_valid hold until the next accepted start.
- Latency: start sampled at edge k gives done high in cycle k+STREAM_LEN+NET_LATENCY+2.
- Simultaneous events:
  - start while busy is ignored; no queueing.
  - abort in any non-IDLE state goes to IDLE next cycle with net_en=0, result_valid=0, no done; abort outranks DONE.
  - abort and start together in IDLE: start wins.
- rst mid-operation returns all outputs to reset values immediately.
- data_in changes after the start cycle have no effect on the running evaluation.

Test Plan:
- Bench model: net_bit_in = net_bits_out[0] delayed NET_LATENCY cycles. data_in ch0=0, start pulse -> net_clr one cycle, net_en high exactly 256 cycles, done exactly 260 cycles after the start edge, result=0, result_valid=1.
- ch0=255 -> result equals the reference-model count of r_0<255 over 256 LFSR steps from seed ACE1, and lies in 250..256; a repeat start gives an identical result (seed reload).
- ch0=124, ch1=82 -> each net_bits_out[i] matches the cycle-accurate LFSR/comparator model; result matches the model for ch0.
- Mid-RUN (cycle 100): pulse abort -> next cycle busy=0, net_en=0, no done, result_valid=0. Then start -> full evaluation completes normally.
- start held high throughout -> evaluations run back-to-back with one IDLE cycle between DONE and LOAD; extra start pulses while busy produce no extra done.
- rst asserted during DRAIN, asynchronously between edges -> outputs go to reset values before the next edge. Also rerun the first scenario with NET_LATENCY=0 and STREAM_LEN=1: done 3 cycles after the start edge.
